// File: rtl/move_commit_ctrl_if.sv
// Move-request handshake and map RAM bus for move_commit_ctrl.
// master = the move controller, slave = requester plus map RAM.
interface move_commit_ctrl_if #(
   parameter int unsigned ADDR_W = 16
) ();
   logic              move_valid;
   logic [1:0]        move_dir;
   logic              move_ready;
   logic              move_done;
   logic              move_blocked;
   logic [ADDR_W-1:0] map_addr;
   logic [15:0]       map_rd_data;
   logic              map_we;
   logic [15:0]       map_wr_data;

   modport master (
      input  move_valid, move_dir, map_rd_data,
      output move_ready, move_done, move_blocked, map_addr, map_we, map_wr_data
   );

   modport slave (
      output move_valid, move_dir, map_rd_data,
      input  move_ready, move_done, move_blocked, map_addr, map_we, map_wr_data
   );
endinterface

// File: rtl/move_commit_ctrl.sv
// Accepts a player move, fetches the target tile and commits the resolver's results.
// Define MOVE_QUEUE_EN to add a one-entry pending-direction buffer.
module move_commit_ctrl #(
   parameter int unsigned MAP_W       = 11,
   parameter int unsigned MAP_H       = 11,
   parameter int unsigned MAX_FLOOR   = 9,
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned START_X     = 5,
   parameter int unsigned START_Y     = 10,
   parameter int unsigned INIT_HEALTH = 100
) (
   input  logic                clk,
   input  logic                rst_n,
   move_commit_ctrl_if.master  bus,
   output logic [3:0]          rs_pos_x,
   output logic [3:0]          rs_pos_y,
   output logic [15:0]         rs_tile_id,
   input  logic [15:0]         rs_floor_out,
   input  logic [3:0]          rs_goto_x,
   input  logic [3:0]          rs_goto_y,
   input  logic [3:0]          rs_key_num_out,
   input  logic [15:0]         rs_health_out,
   input  logic [15:0]         rs_new_tile_id,
   output logic [15:0]         floor,
   output logic [3:0]          player_x,
   output logic [3:0]          player_y,
   output logic [3:0]          key_num,
   output logic [15:0]         health
);

   localparam int unsigned TILES = MAP_W * MAP_H;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT,
      RESOLVE,
      COMMIT,
      DONE
   } state_t;

   state_t            state, state_n;
   logic              blocked_r;
   logic              launch;
   logic [1:0]        launch_dir;
   logic              oob;
   logic [3:0]        tgt_x, tgt_y;
   logic              commit_ok;
   logic              tile_write;
   logic              commit_blk;
   logic [3:0]        key_next;
   logic [ADDR_W-1:0] tgt_addr;

`ifdef MOVE_QUEUE_EN
   logic              pend_valid;
   logic [1:0]        pend_dir;
   logic              accepted;
   logic              direct;
   logic              store;
   logic              consume;
`endif

   // Address of the latched target on the current (pre-move) floor
   assign tgt_addr = ADDR_W'(floor) * ADDR_W'(TILES)
                   + ADDR_W'(rs_pos_y) * ADDR_W'(MAP_W)
                   + ADDR_W'(rs_pos_x);

   assign commit_ok  = (rs_floor_out <= 16'(MAX_FLOOR));
   assign tile_write = commit_ok && (rs_new_tile_id != rs_tile_id);
   assign commit_blk = !commit_ok
                     || ((rs_goto_x == player_x) && (rs_goto_y == player_y)
                         && (rs_floor_out == floor) && !tile_write);
   assign key_next   = ((key_num == 4'hF) && (rs_key_num_out == 4'h0)) ? 4'hF : rs_key_num_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n    = state;
      launch     = 1'b0;
      launch_dir = bus.move_dir;
      oob        = 1'b0;
      tgt_x      = player_x;
      tgt_y      = player_y;

      case (state)
         IDLE: begin
`ifdef MOVE_QUEUE_EN
            if (pend_valid) begin
               launch     = 1'b1;
               launch_dir = pend_dir;
            end else if (bus.move_valid) begin
               launch = 1'b1;
            end
`else
            if (bus.move_valid) begin
               launch = 1'b1;
            end
`endif
         end
         READ:    state_n = WAIT;
         WAIT:    state_n = RESOLVE;
         RESOLVE: state_n = COMMIT;
         COMMIT:  state_n = DONE;
         DONE: begin
            state_n = IDLE;
`ifdef MOVE_QUEUE_EN
            // A queued move skips IDLE and goes straight to the bounds check
            if (pend_valid) begin
               launch     = 1'b1;
               launch_dir = pend_dir;
            end
`endif
         end
         default: state_n = IDLE;
      endcase

      case (launch_dir)
         2'd0: begin
            if (player_y == 4'd0) oob = 1'b1;
            else                  tgt_y = player_y - 4'd1;
         end
         2'd1: begin
            if (player_y == 4'(MAP_H - 1)) oob = 1'b1;
            else                           tgt_y = player_y + 4'd1;
         end
         2'd2: begin
            if (player_x == 4'd0) oob = 1'b1;
            else                  tgt_x = player_x - 4'd1;
         end
         default: begin
            if (player_x == 4'(MAP_W - 1)) oob = 1'b1;
            else                           tgt_x = player_x + 4'd1;
         end
      endcase

      if (launch) begin
         state_n = oob ? DONE : READ;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs_pos_x   <= '0;
         rs_pos_y   <= '0;
         rs_tile_id <= '0;
         blocked_r  <= 1'b0;
         floor      <= '0;
         player_x   <= 4'(START_X);
         player_y   <= 4'(START_Y);
         key_num    <= '0;
         health     <= 16'(INIT_HEALTH);
      end else begin
         if (launch) begin
            blocked_r <= oob;
            if (!oob) begin
               rs_pos_x <= tgt_x;
               rs_pos_y <= tgt_y;
            end
         end
         if (state == RESOLVE) begin
            rs_tile_id <= bus.map_rd_data;
         end
         if (state == COMMIT) begin
            blocked_r <= commit_blk;
            if (commit_ok) begin
               floor    <= rs_floor_out;
               player_x <= rs_goto_x;
               player_y <= rs_goto_y;
               key_num  <= key_next;
               health   <= rs_health_out;
            end
         end
      end
   end

`ifdef MOVE_QUEUE_EN
   assign accepted = bus.move_valid && bus.move_ready;
   assign direct   = (state == IDLE) && !pend_valid;
   assign store    = accepted && !direct;
   assign consume  = ((state == IDLE) || (state == DONE)) && pend_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_valid <= 1'b0;
         pend_dir   <= '0;
      end else if (store) begin
         pend_valid <= 1'b1;
         pend_dir   <= bus.move_dir;
      end else if (consume) begin
         pend_valid <= 1'b0;
      end
   end

   assign bus.move_ready = (state == IDLE) || !pend_valid;
`else
   assign bus.move_ready = (state == IDLE);
`endif

   // Address is held from READ through COMMIT so the RAM output stays on the target
   assign bus.map_addr     = ((state == READ) || (state == WAIT) || (state == RESOLVE)
                              || (state == COMMIT)) ? tgt_addr : '0;
   assign bus.map_we       = (state == COMMIT) && tile_write;
   assign bus.map_wr_data  = rs_new_tile_id;
   assign bus.move_done    = (state == DONE);
   assign bus.move_blocked = (state == DONE) && blocked_r;

   a_blocked_with_done: assert property (@(posedge clk) disable iff (!rst_n)
      bus.move_blocked |-> bus.move_done);
   a_write_legal_floor: assert property (@(posedge clk) disable iff (!rst_n)
      bus.map_we |-> (rs_floor_out <= 16'(MAX_FLOOR)));

endmodule

// File: tb/tb_move_commit_ctrl.sv
// Testbench for move_commit_ctrl: map RAM, rule-based tile resolver and a move-level reference model.
module tb_move_commit_ctrl;
   localparam int MAP_W     = 11;
   localparam int MAP_H     = 11;
   localparam int MAX_FLOOR = 9;
   localparam int MEM_N     = 2048;
   localparam logic [15:0] T_GROUND  = 16'd0;
   localparam logic [15:0] T_WALL    = 16'd1;
   localparam logic [15:0] T_KEY     = 16'd2;
   localparam logic [15:0] T_UP      = 16'd3;
   localparam logic [15:0] T_DOWN    = 16'd4;
   localparam logic [15:0] T_MONSTER = 16'd5;
   localparam logic [15:0] T_DOOR    = 16'd6;

   typedef struct packed {
      logic [15:0] f;
      logic [3:0]  gx;
      logic [3:0]  gy;
      logic [3:0]  k;
      logic [15:0] h;
      logic [15:0] nt;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   move_commit_ctrl_if #(.ADDR_W(16)) bus ();

   logic [3:0]  rs_pos_x, rs_pos_y, rs_goto_x, rs_goto_y, rs_key_num_out;
   logic [3:0]  player_x, player_y, key_num;
   logic [15:0] rs_tile_id, rs_floor_out, rs_health_out, rs_new_tile_id, floor, health;
   res_t        res_now;

   move_commit_ctrl #(
      .MAP_W(11), .MAP_H(11), .MAX_FLOOR(9), .ADDR_W(16),
      .START_X(5), .START_Y(10), .INIT_HEALTH(100)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .rs_pos_x(rs_pos_x), .rs_pos_y(rs_pos_y), .rs_tile_id(rs_tile_id),
      .rs_floor_out(rs_floor_out), .rs_goto_x(rs_goto_x), .rs_goto_y(rs_goto_y),
      .rs_key_num_out(rs_key_num_out), .rs_health_out(rs_health_out),
      .rs_new_tile_id(rs_new_tile_id),
      .floor(floor), .player_x(player_x), .player_y(player_y),
      .key_num(key_num), .health(health)
   );

   // Game rules applied by the external resolver
   function automatic res_t resolve(input logic [15:0] tile, input logic [15:0] f,
                                    input logic [3:0] x, input logic [3:0] y,
                                    input logic [3:0] tx, input logic [3:0] ty,
                                    input logic [3:0] k, input logic [15:0] h);
      res_t r;
      r.f = f; r.gx = x; r.gy = y; r.k = k; r.h = h; r.nt = tile;
      case (tile)
         T_GROUND:  begin r.gx = tx; r.gy = ty; end
         T_KEY:     begin r.k = k + 4'd1; r.nt = T_GROUND; r.gx = tx; r.gy = ty; end
         T_UP:      r.f = f + 16'd1;
         T_DOWN:    r.f = f - 16'd1;
         T_MONSTER: begin r.h = h - 16'd10; r.nt = T_GROUND; end
         T_DOOR:    if (k != 4'd0) begin r.k = k - 4'd1; r.nt = T_GROUND; r.gx = tx; r.gy = ty; end
         default:   ;
      endcase
      return r;
   endfunction

   assign res_now        = resolve(rs_tile_id, floor, player_x, player_y, rs_pos_x, rs_pos_y, key_num, health);
   assign rs_floor_out   = res_now.f;
   assign rs_goto_x      = res_now.gx;
   assign rs_goto_y      = res_now.gy;
   assign rs_key_num_out = res_now.k;
   assign rs_health_out  = res_now.h;
   assign rs_new_tile_id = res_now.nt;

   // Map RAM with a backdoor for setup while the controller is idle
   logic [15:0] mem [0:MEM_N-1];
   logic        bd_we, bd_clr;
   logic [10:0] bd_addr;
   logic [15:0] bd_data;

   always @(posedge clk) begin
      if (bd_clr) begin
         for (int i = 0; i < MEM_N; i++) mem[i] <= '0;
      end else if (bd_we) begin
         mem[bd_addr] <= bd_data;
      end else if (bus.map_we) begin
         mem[bus.map_addr[10:0]] <= bus.map_wr_data;
      end
      bus.map_rd_data <= mem[bus.map_addr[10:0]];
   end

   int n_checks, n_fail;
   int m_floor, m_x, m_y, m_key, m_health;
   logic [15:0] m_mem [0:MEM_N-1];

   function automatic int addr_of(input int f, input int x, input int y);
      return f * MAP_W * MAP_H + y * MAP_W + x;
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.move_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_floor = 0; m_x = 5; m_y = 10; m_key = 0; m_health = 100;
   endtask

   task automatic clear_map();
      @(negedge clk); bd_clr = 1'b1;
      @(negedge clk); bd_clr = 1'b0;
      for (int i = 0; i < MEM_N; i++) m_mem[i] = T_GROUND;
   endtask

   task automatic set_tile(input int a, input logic [15:0] v);
      @(negedge clk);
      bd_we = 1'b1; bd_addr = 11'(a); bd_data = v;
      @(negedge clk);
      bd_we = 1'b0;
      m_mem[a] = v;
   endtask

   // Reference: outcome of one move from the game rules, expressed per move
   task automatic model_move(input logic [1:0] dir, output logic e_blk, output logic e_we,
                             output int e_addr, output logic [15:0] e_data,
                             output int e_done, output int e_rd);
      int nx, ny, a;
      logic [15:0] tile;
      res_t r;
      nx = m_x; ny = m_y;
      case (dir)
         2'd0: ny = ny - 1;
         2'd1: ny = ny + 1;
         2'd2: nx = nx - 1;
         default: nx = nx + 1;
      endcase
      e_we = 1'b0; e_addr = 0; e_data = '0; e_rd = 0;
      if (nx < 0 || nx >= MAP_W || ny < 0 || ny >= MAP_H) begin
         e_blk = 1'b1; e_done = 0;
         return;
      end
      e_done = 4;
      a = addr_of(m_floor, nx, ny);
      e_rd = a;
      tile = m_mem[a];
      r = resolve(tile, 16'(m_floor), 4'(m_x), 4'(m_y), 4'(nx), 4'(ny), 4'(m_key), 16'(m_health));
      if (int'(r.f) > MAX_FLOOR) begin
         e_blk = 1'b1;
         return;
      end
      e_we = (r.nt != tile);
      if (e_we) begin
         m_mem[a] = r.nt; e_addr = a; e_data = r.nt;
      end
      e_blk = (int'(r.gx) == m_x) && (int'(r.gy) == m_y) && (int'(r.f) == m_floor) && !e_we;
      m_key    = (m_key == 15 && r.k == 4'd0) ? 15 : int'(r.k);
      m_floor  = int'(r.f);
      m_x      = int'(r.gx);
      m_y      = int'(r.gy);
      m_health = int'(r.h);
   endtask

   // Drives one request and records what the controller does, cycle-indexed from the accept edge
   task automatic run_move(input logic [1:0] dir, output int done_c, output logic blk,
                           output int we_c, output int we_a, output logic [15:0] we_d, output int rd_a);
      int n;
      @(negedge clk);
      bus.move_valid = 1'b1; bus.move_dir = dir;
      n = 0;
      while (!bus.move_ready && n < 50) begin
         @(negedge clk); n++;
      end
      @(posedge clk);
      #1;
      bus.move_valid = 1'b0;
      bus.move_dir = 2'($urandom);
      done_c = -1; we_c = -1; we_a = 0; we_d = '0; blk = 1'b0; rd_a = -1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (c == 0) rd_a = int'(bus.map_addr);
         if (bus.map_we && we_c < 0) begin
            we_c = c; we_a = int'(bus.map_addr); we_d = bus.map_wr_data;
         end
         if (bus.move_done) begin
            done_c = c; blk = bus.move_blocked;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_checks++;
      if ({floor, player_x, player_y, key_num, health} !== {16'd0, 4'd5, 4'd10, 4'd0, 16'd100}) begin
         n_fail++;
         $display("FAIL reset_state: got f=%0d x=%0d y=%0d k=%0d h=%0d want 0 5 10 0 100",
                  floor, player_x, player_y, key_num, health);
      end
      n_checks++;
      if ({bus.map_we, bus.move_done, bus.move_blocked, bus.map_addr, rs_tile_id} !== {3'b000, 16'd0, 16'd0}) begin
         n_fail++;
         $display("FAIL reset_outputs: got we=%b done=%b blk=%b addr=%0d tile=%0d want all 0",
                  bus.map_we, bus.move_done, bus.move_blocked, bus.map_addr, rs_tile_id);
      end
      apply_reset();
      n_checks++;
      if (bus.move_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready: got %b want 1", bus.move_ready);
      end
   endtask

   task automatic test_right_ground();
      int dc, wc, wa, ra, edc, ewa, era; logic bk, ebk, ewe; logic [15:0] wd, ewd;
      apply_reset(); clear_map();
      model_move(2'd3, ebk, ewe, ewa, ewd, edc, era);
      run_move(2'd3, dc, bk, wc, wa, wd, ra);
      n_checks++;
      if (ra !== 116) begin n_fail++; $display("FAIL right_rd_addr: got %0d want 116", ra); end
      n_checks++;
      if (dc !== 4) begin n_fail++; $display("FAIL right_done_cycle: got %0d want 4", dc); end
      n_checks++;
      if (bk !== 1'b0 || wc !== -1) begin n_fail++; $display("FAIL right_blk_we: got blk=%b we_cyc=%0d want 0 -1", bk, wc); end
      n_checks++;
      if (player_x !== 4'd6 || player_y !== 4'd10) begin n_fail++; $display("FAIL right_pos: got %0d,%0d want 6,10", player_x, player_y); end
   endtask

   task automatic test_key_write();
      int dc, wc, wa, ra, edc, ewa, era; logic bk, ebk, ewe; logic [15:0] wd, ewd;
      apply_reset(); clear_map();
      set_tile(116, T_KEY);
      model_move(2'd3, ebk, ewe, ewa, ewd, edc, era);
      run_move(2'd3, dc, bk, wc, wa, wd, ra);
      n_checks++;
      if (wc !== 3) begin n_fail++; $display("FAIL key_we_cycle: got %0d want 3", wc); end
      n_checks++;
      if (wa !== 116 || wd !== T_GROUND) begin n_fail++; $display("FAIL key_write: got addr=%0d data=%0d want 116 0", wa, wd); end
      n_checks++;
      if (key_num !== 4'd1 || dc !== 4 || bk !== 1'b0) begin
         n_fail++; $display("FAIL key_state: got k=%0d done=%0d blk=%b want 1 4 0", key_num, dc, bk);
      end
   endtask

   task automatic test_bounds();
      int dc, wc, wa, ra, edc, ewa, era; logic bk, ebk, ewe; logic [15:0] wd, ewd;
      apply_reset(); clear_map();
      model_move(2'd1, ebk, ewe, ewa, ewd, edc, era);
      run_move(2'd1, dc, bk, wc, wa, wd, ra);
      n_checks++;
      if (dc !== 0 || bk !== 1'b1 || ra !== 0) begin
         n_fail++; $display("FAIL bottom_edge: got done=%0d blk=%b addr=%0d want 0 1 0", dc, bk, ra);
      end
      for (int i = 0; i < 5; i++) begin
         model_move(2'd2, ebk, ewe, ewa, ewd, edc, era);
         run_move(2'd2, dc, bk, wc, wa, wd, ra);
      end
      n_checks++;
      if (player_x !== 4'd0) begin n_fail++; $display("FAIL walk_left: got x=%0d want 0", player_x); end
      model_move(2'd2, ebk, ewe, ewa, ewd, edc, era);
      run_move(2'd2, dc, bk, wc, wa, wd, ra);
      n_checks++;
      if (dc !== 0 || bk !== 1'b1 || ra !== 0 || wc !== -1) begin
         n_fail++; $display("FAIL left_edge: got done=%0d blk=%b addr=%0d we_cyc=%0d want 0 1 0 -1", dc, bk, ra, wc);
      end
      n_checks++;
      if (player_x !== 4'd0 || player_y !== 4'd10) begin n_fail++; $display("FAIL left_edge_pos: got %0d,%0d want 0,10", player_x, player_y); end
   endtask

   task automatic test_floor_wrap();
      int dc, wc, wa, ra, edc, ewa, era; logic bk, ebk, ewe; logic [15:0] wd, ewd;
      apply_reset(); clear_map();
      set_tile(116, T_DOWN);
      model_move(2'd3, ebk, ewe, ewa, ewd, edc, era);
      run_move(2'd3, dc, bk, wc, wa, wd, ra);
      n_checks++;
      if (bk !== 1'b1 || dc !== 4 || wc !== -1) begin
         n_fail++; $display("FAIL downstair_f0: got blk=%b done=%0d we_cyc=%0d want 1 4 -1", bk, dc, wc);
      end
      n_checks++;
      if (floor !== 16'd0 || player_x !== 4'd5) begin n_fail++; $display("FAIL downstair_state: got f=%0d x=%0d want 0 5", floor, player_x); end
   endtask

   task automatic test_key_saturate();
      int dc, wc, wa, ra, edc, ewa, era; logic bk, ebk, ewe; logic [15:0] wd, ewd;
      logic [1:0] dir;
      apply_reset(); clear_map();
      for (int i = 1; i <= 16; i++) begin
         dir = (i % 2 == 1) ? 2'd3 : 2'd2;
         set_tile(addr_of(0, (i % 2 == 1) ? 6 : 5, 10), T_KEY);
         model_move(dir, ebk, ewe, ewa, ewd, edc, era);
         run_move(dir, dc, bk, wc, wa, wd, ra);
         n_checks++;
         if (key_num !== 4'(m_key)) begin n_fail++; $display("FAIL key_count_%0d: got %0d want %0d", i, key_num, m_key); end
      end
      n_checks++;
      if (key_num !== 4'd15) begin n_fail++; $display("FAIL key_saturate: got %0d want 15", key_num); end
      n_checks++;
      if (wc !== 3 || wd !== T_GROUND) begin n_fail++; $display("FAIL key_sat_write: got we_cyc=%0d data=%0d want 3 0", wc, wd); end
   endtask

   task automatic test_random();
      int dc, wc, wa, ra, edc, ewa, era; logic bk, ebk, ewe; logic [15:0] wd, ewd;
      logic [1:0] dir;
      int sel;
      logic [15:0] t;
      apply_reset();
      for (int a = 0; a < (MAX_FLOOR + 1) * MAP_W * MAP_H; a++) begin
         sel = $urandom_range(0, 11);
         case (sel)
            4: t = T_WALL;  5: t = T_KEY;     6: t = T_UP;
            7: t = T_DOWN;  8: t = T_MONSTER; 9: t = T_DOOR;
            default: t = T_GROUND;
         endcase
         set_tile(a, t);
      end
      for (int i = 0; i < 80; i++) begin
         dir = 2'($urandom);
         model_move(dir, ebk, ewe, ewa, ewd, edc, era);
         run_move(dir, dc, bk, wc, wa, wd, ra);
         n_checks++;
         if (dc !== edc || bk !== ebk) begin
            n_fail++; $display("FAIL rand_done_%0d: got done=%0d blk=%b want %0d %b", i, dc, bk, edc, ebk);
         end
         n_checks++;
         if (wc !== (ewe ? 3 : -1)) begin n_fail++; $display("FAIL rand_we_cycle_%0d: got %0d want %0d", i, wc, ewe ? 3 : -1); end
         if (ewe) begin
            n_checks++;
            if (wa !== ewa || wd !== ewd) begin
               n_fail++; $display("FAIL rand_write_%0d: got addr=%0d data=%0d want %0d %0d", i, wa, wd, ewa, ewd);
            end
         end
         n_checks++;
         if (ra !== era) begin n_fail++; $display("FAIL rand_rd_addr_%0d: got %0d want %0d", i, ra, era); end
         n_checks++;
         if ({floor, player_x, player_y, key_num, health} !==
             {16'(m_floor), 4'(m_x), 4'(m_y), 4'(m_key), 16'(m_health)}) begin
            n_fail++;
            $display("FAIL rand_state_%0d: got f=%0d x=%0d y=%0d k=%0d h=%0d want %0d %0d %0d %0d %0d",
                     i, floor, player_x, player_y, key_num, health, m_floor, m_x, m_y, m_key, m_health & 16'hFFFF);
         end
      end
   endtask

   task automatic test_reset_commit();
      int dc, wc, wa, ra, edc, ewa, era, c; logic bk, ebk, ewe; logic [15:0] wd, ewd;
      apply_reset(); clear_map();
      set_tile(116, T_KEY);
      @(negedge clk);
      bus.move_valid = 1'b1; bus.move_dir = 2'd3;
      @(posedge clk);
      #1;
      bus.move_valid = 1'b0;
      c = 0;
      while (c < 10) begin
         @(negedge clk);
         if (bus.map_we) break;
         c++;
      end
      n_checks++;
      if (c >= 10) begin n_fail++; $display("FAIL rc_reach_commit: got no map_we within 10 cycles want map_we"); end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.map_we !== 1'b0) begin n_fail++; $display("FAIL rc_we_drop: got %b want 0", bus.map_we); end
      n_checks++;
      if ({key_num, player_x, player_y, health, rs_tile_id, bus.move_ready} !== {4'd0, 4'd5, 4'd10, 16'd100, 16'd0, 1'b1}) begin
         n_fail++; $display("FAIL rc_regs: got k=%0d x=%0d y=%0d h=%0d tile=%0d rdy=%b want 0 5 10 100 0 1",
                            key_num, player_x, player_y, health, rs_tile_id, bus.move_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      m_floor = 0; m_x = 5; m_y = 10; m_key = 0; m_health = 100;
      model_move(2'd3, ebk, ewe, ewa, ewd, edc, era);
      run_move(2'd3, dc, bk, wc, wa, wd, ra);
      n_checks++;
      if (key_num !== 4'd1 || wc !== 3 || wa !== 116 || dc !== 4) begin
         n_fail++; $display("FAIL rc_next_move: got k=%0d we_cyc=%0d addr=%0d done=%0d want 1 3 116 4", key_num, wc, wa, dc);
      end
   endtask

`ifdef MOVE_QUEUE_EN
   task automatic test_back_to_back();
      int edc, ewa, era, done1, done2, rd2; logic ebk, ewe; logic [15:0] ewd;
      apply_reset(); clear_map();
      model_move(2'd3, ebk, ewe, ewa, ewd, edc, era);
      model_move(2'd3, ebk, ewe, ewa, ewd, edc, era);
      @(negedge clk);
      bus.move_valid = 1'b1; bus.move_dir = 2'd3;
      @(posedge clk);
      #1;
      bus.move_dir = 2'd3;
      @(posedge clk);
      #1;
      bus.move_valid = 1'b0;
      done1 = -1; done2 = -1; rd2 = -1;
      for (int c = 1; c < 25; c++) begin
         @(negedge clk);
         if (c == 5) rd2 = int'(bus.map_addr);
         if (bus.move_done) begin
            if (done1 < 0) done1 = c;
            else begin done2 = c; break; end
         end
      end
      n_checks++;
      if (done1 !== 4 || done2 !== 9) begin n_fail++; $display("FAIL b2b_done: got %0d %0d want 4 9", done1, done2); end
      n_checks++;
      if (rd2 !== 117) begin n_fail++; $display("FAIL b2b_second_read: got %0d want 117", rd2); end
      n_checks++;
      if (player_x !== 4'(m_x)) begin n_fail++; $display("FAIL b2b_pos: got %0d want %0d", player_x, m_x); end
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0; n_fail = 0;
      bus.move_valid = 1'b0; bus.move_dir = 2'd0;
      bd_we = 1'b0; bd_clr = 1'b0; bd_addr = '0; bd_data = '0;
      test_reset();
      test_right_ground();
      test_key_write();
      test_bounds();
      test_floor_wrap();
      test_key_saturate();
      test_random();
      test_reset_commit();
`ifdef MOVE_QUEUE_EN
      test_back_to_back();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/move_commit_ctrl.md
Name: move_commit_ctrl

Overview:
- Initiator and committer for player moves in the tower game.
- Accepts a direction request and reads the target tile from map RAM.
- Presents the tile and current player state to the combinational tile-interaction resolver, then commits the results: writes the new tile back to map RAM and updates the floor, position, key and health registers.
- Owns the player-state registers consumed by the render and HUD logic.

Parameters:
- MAP_W, 11, tiles per row
- MAP_H, 11, tiles per column
- MAX_FLOOR, 9, highest legal floor index
- ADDR_W, 16, map RAM address width
- START_X, 5, reset player x
- START_Y, 10, reset player y
- INIT_HEALTH, 100, reset health

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- move_valid  in  1  move request
- move_dir  in  2  0=up(y-1), 1=down(y+1), 2=left(x-1), 3=right(x+1)
- move_ready  out  1  request accepted when valid&ready
- move_done  out  1  one-cycle pulse; registers already hold the post-move state
- move_blocked  out  1  valid with move_done; move produced no state change
- map_addr  out  ADDR_W  floor*MAP_W*MAP_H + y*MAP_W + x
- map_rd_data  in  16  synchronous read data, 1-cycle latency
- map_we  out  1  write strobe
- map_wr_data  out  16  tile id to write
- rs_pos_x / rs_pos_y  out  4 each  target position to resolver
- rs_tile_id  out  16  registered target tile
- rs_floor_out, rs_goto_x, rs_goto_y, rs_key_num_out, rs_health_out, rs_new_tile_id  in  16/4/4/4/16/16  resolver results
- floor  out  16  current floor
- player_x / player_y  out  4 each  current position
- key_num  out  4  current keys
- health  out  16  current health

Behaviour:
- The clock is clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, floor=0, player_x=START_X, player_y=START_Y, key_num=0, health=INIT_HEALTH, rs_tile_id=0, map_we=0, move_done=0, move_blocked=0, map_addr=0.
- FSM states: IDLE, READ, WAIT, RESOLVE, COMMIT, DONE.
- IDLE: move_ready=1. On valid&ready, compute the target from move_dir.
  - If the target leaves the grid (x=0 & left, x=MAP_W-1 & right, y=0 & up, y=MAP_H-1 & down), go to DONE with blocked=1.
  - Otherwise latch the target into rs_pos and go to READ.
- READ: drive map_addr for the target.
- WAIT: RAM data returns.
- RESOLVE: latch map_rd_data into rs_tile_id.
- COMMIT: resolver outputs are stable.
  - Illegal floor: if rs_floor_out > MAX_FLOOR (includes the 0-1 wrap to 0xFFFF), the move is blocked. No register update, no write.
  - Otherwise, at the end of the cycle, load floor, player_x, player_y, key_num and health from rs_* outputs.
  - key_num saturates: if key_num=15 and rs_key_num_out=0, hold 15.
  - If rs_new_tile_id != rs_tile_id, assert map_we for this single cycle with map_addr = target on the pre-move floor.
  - blocked=1 when goto equals the old position, floor is unchanged and no write occurs.
- DONE: move_done=1 for one cycle (with move_blocked), then go to IDLE.
- move_ready=0 in every state except IDLE.
- Latency: accept at cycle T → map_we at T+3 → move_done at T+4. Next accept is possible at T+5.
- move_dir is sampled only at accept; later changes are ignored.
- Reset mid-operation: immediate return to IDLE, map_we drops asynchronously, no partial commit.

Optional Feature:
- Macro: MOVE_QUEUE_EN.
- With MOVE_QUEUE_EN defined:
  - Adds a one-entry pending-direction buffer.
  - move_ready = (state==IDLE) | ~pending_valid.
  - A request accepted while busy is stored.
  - DONE goes directly to the target-computation step using the pending entry. The next move is the bounds check/READ immediately after DONE, without an IDLE cycle.
  - Reset clears pending_valid.
- Without it: move_ready is high only in IDLE; the requester holds move_valid.

Test Plan:
- Reset, then a right move with tile=ground(id 0) and resolver passthrough → map reads at addr 0*121+10*11+6=116; player_x=6; no map_we; move_done at T+4; blocked=0.
- Key tile at the target, resolver key_num_out=1, new_tile=ground → map_we at T+3 with map_wr_data=ground at the target addr; key_num=1.
- Player at x=0, move left → no map read; move_done one cycle after accept; blocked=1; state unchanged.
- Downstair on floor 0, resolver floor_out=0xFFFF → blocked=1; floor stays 0; no write.
- key_num=15, resolver returns 0 → key_num stays 15; tile write still occurs.
- rst_n pulsed low during COMMIT → map_we falls in the same cycle; registers return to reset values; next move starts cleanly. With MOVE_QUEUE_EN, two back-to-back requests both complete, and the second READ occurs immediately after the first DONE.
